// File: rtl/world_hour_scheduler_if.sv
// Converter bus between the hour scheduler and the shared hour-transfer converter.
interface world_hour_scheduler_if;
   logic [2:0] w_count;
   logic [6:0] hour_conv;
   logic [6:0] hour_w;

   modport master (output w_count, output hour_conv, input hour_w);
   modport slave  (input w_count, input hour_conv, output hour_w);
endinterface

// File: rtl/world_hour_scheduler.sv
// Time-shares the hour-transfer converter across four cities, shadows the results
// and commits them atomically to the display table.
//
// state  | meaning
// IDLE   | wait for a local-hour change (or the post-reset INIT) with a valid hour
// SWEEP  | step the converter select 0..3, capturing one city per clock into shadow
// COMMIT | copy shadow into the display table in one edge, pulse done
module world_hour_scheduler #(
   parameter int NCITY = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            hour,
   input  logic                  city_btn,
   world_hour_scheduler_if.master conv,
   output logic [1:0]            disp_sel,
   output logic [6:0]            disp_hour,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, SWEEP, COMMIT} state_t;

   localparam logic [2:0] LAST_CITY = 3'(NCITY - 1);

   state_t     state;
   logic       init;
   logic       trigger;
   logic [6:0] shadow     [NCITY];
   logic [6:0] disp_table [NCITY];

   assign err       = (hour > 7'd23);
   assign trigger   = ((hour != conv.hour_conv) || init) && !err;
   assign disp_hour = disp_table[disp_sel];

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         init           <= 1'b1;
         conv.w_count   <= 3'd0;
         conv.hour_conv <= 7'd0;
         disp_sel       <= 2'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         for (int i = 0; i < NCITY; i++) begin
            shadow[i]     <= 7'd0;
            disp_table[i] <= 7'd0;
         end
      end else begin
         done <= 1'b0;
         if (city_btn)
            disp_sel <= disp_sel + 2'd1;

         case (state)
            IDLE: begin
               if (trigger) begin
                  conv.hour_conv <= hour;
                  conv.w_count   <= 3'd0;
                  init           <= 1'b0;
                  busy           <= 1'b1;
                  state          <= SWEEP;
               end
            end
            SWEEP: begin
               shadow[conv.w_count[1:0]] <= conv.hour_w;
               if (conv.w_count == LAST_CITY) begin
                  conv.w_count <= 3'd0;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  state        <= COMMIT;
               end else begin
                  conv.w_count <= conv.w_count + 3'd1;
               end
            end
            COMMIT: begin
               // done is already high for this cycle; the table lands on this edge
               for (int i = 0; i < NCITY; i++)
                  disp_table[i] <= shadow[i];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/world_hour_scheduler.md
# world_hour_scheduler

Sequencer that time-shares the single combinational hour-transfer converter across all four world-clock cities. It detects a change of the local hour, sweeps the converter's city select 0..3 one city per clock, and captures each converted hour into a shadow table. The shadow table is committed atomically to a display table that feeds the 7-segment hour path. A city button selects which committed entry is shown.

## Interface
Parameters:
- NCITY, 4, number of cities swept; fixed at 4, matching the converter's 3-bit select values 0..3.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- HOUR  in  7  local hour, 0..23, from the timekeeping counter.
- CITY_BTN  in  1  one-cycle pulse, already debounced; advances the displayed city.
- W_COUNT  out  3  city select driven to the converter; registered.
- HOUR_CONV  out  7  hour snapshot driven to the converter's HOUR input; registered.
- HOUR_W  in  7  converter result, combinational from W_COUNT and HOUR_CONV.
- DISP_SEL  out  2  currently displayed city, 0..3.
- DISP_HOUR  out  7  committed converted hour for DISP_SEL; combinational mux of the display table.
- BUSY  out  1  high in the SWEEP state.
- DONE  out  1  one-cycle pulse when the display table is committed.
- ERR  out  1  high while HOUR > 23; combinational from HOUR.

## Operation
- Converter mapping, per city: 0: +2 h; 1: −1 h; 2: −14 h; 3: −9 h. All results wrap modulo 24. The arithmetic is inside the converter; this block only sequences it.
- State machine has three states: IDLE, SWEEP, COMMIT.
- IDLE:
  - Sweep trigger is (HOUR != HOUR_CONV or INIT) and HOUR <= 23.
  - On a trigger: HOUR_CONV <= HOUR, W_COUNT <= 0, INIT <= 0, next state SWEEP.
  - With no trigger, stay in IDLE.
- SWEEP:
  - Each cycle: shadow[W_COUNT] <= HOUR_W.
  - If W_COUNT == 3, go to COMMIT and set W_COUNT <= 0. Otherwise W_COUNT <= W_COUNT + 1.
- COMMIT: disp_table <= shadow (all four entries in one edge), DONE = 1, next state IDLE.
- HOUR_CONV stays frozen from snapshot until the next IDLE trigger. A HOUR change during SWEEP or COMMIT is ignored until the block returns to IDLE; the comparison there then starts a new sweep.
- HOUR > 23:
  - ERR is high.
  - No trigger is taken.
  - The display table holds its last committed value.
- CITY_BTN is accepted in every state. Each high cycle sets DISP_SEL <= DISP_SEL + 1, wrapping 3 -> 0.
- DISP_HOUR = disp_table[DISP_SEL]. It never shows a partially swept table.
- Reset values:
  - State = IDLE, INIT = 1.
  - W_COUNT = 0, HOUR_CONV = 0.
  - Shadow and disp_table all 0.
  - DISP_SEL = 0, DISP_HOUR = 0.
  - BUSY = 0, DONE = 0.

## Timing
- Edge numbering: edge k is the first edge with RESET low at which the block is in IDLE with a valid trigger.
  - Snapshot at edge k.
  - Shadow entries 0..3 written at edges k+1..k+4.
  - Commit at edge k+5.
  - DONE is high in the cycle after edge k+4.
  - DISP_HOUR reflects the new hour after edge k+5.
- Total latency from HOUR change to updated display is 6 edges.
- BUSY is high for exactly 4 cycles per sweep.
- Minimum spacing between consecutive sweeps is 6 cycles; IDLE occupies at least one cycle.
- After reset release the first sweep is forced by INIT, even when HOUR == 0.
- RESET asserted mid-SWEEP:
  - Aborts with no commit; DONE is not pulsed.
  - All registers return to their reset values.
  - INIT forces a fresh sweep afterwards.
- CITY_BTN in the same cycle as COMMIT: DISP_SEL advances and disp_table updates on the same edge. DISP_HOUR then shows the new entry for the new DISP_SEL.

## Test plan
- Reset, then HOUR=10 held -> BUSY high for 4 cycles, DONE pulse; disp_table = {12, 9, 20, 1}; DISP_HOUR=12 with DISP_SEL=0.
- After the table is committed for HOUR=10, pulse CITY_BTN four times -> DISP_HOUR sequence 9, 20, 1, 12; DISP_SEL wraps 3 -> 0.
- Change HOUR 10 -> 23 -> committed table {1, 22, 9, 14}, 6 edges after the change. HOUR 23 -> 0 -> table {2, 23, 10, 15}.
- Change HOUR 5 -> 6 on the second SWEEP cycle:
  - First commit is {7, 4, 15, 20}.
  - A second sweep follows automatically and commits {8, 5, 16, 21}.
  - DISP_HOUR never shows a mix of the two tables.
- Drive HOUR=30 -> ERR=1, no BUSY, table unchanged. Then HOUR=8 -> ERR=0 and sweep commits {10, 7, 18, 23}.
- Assert RESET on the third SWEEP cycle -> no DONE pulse, all outputs 0. After release, with HOUR held, a forced sweep commits the full table.
